// File: rtl/otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// otter_fetch_queue: OTTER fetch PC, one-cycle imem interface and a decoupling
// queue of {pc, ir} feeding decode over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module otter_fetch_queue #(
  parameter int              XLEN      = 32,
  parameter int              QDEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  output logic [XLEN-1:0]              imem_addr,
  output logic                         imem_rden,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         de_valid,
  input  logic                         de_ready,
  output logic [31:0]                  de_ir,
  output logic [XLEN-1:0]              de_pc,
  output logic [XLEN-1:0]              de_pc_inc,
  output logic [$clog2(QDEPTH+1)-1:0]  count
);

  localparam int          PW    = $clog2(QDEPTH);
  localparam int          CW    = $clog2(QDEPTH+1);
  localparam logic [CW:0] QFULL = (CW+1)'(QDEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [XLEN-1:0] q_pc [QDEPTH];
  logic [31:0]     q_ir [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            push;
  logic            issue;

  assign de_valid = (count != '0);
  assign pop      = de_valid & de_ready & ~redirect;
  assign push     = inflight;

  // Entries committed after this edge, counting the in-flight slot; issuing
  // only below QDEPTH keeps the queue from ever overflowing.
  assign occupancy = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};
  assign issue     = ~RST & ~redirect & (occupancy < QFULL);

  assign imem_rden = issue;
  assign imem_addr = fetch_pc;

  assign de_ir     = de_valid ? q_ir[rd_ptr] : NOP;
  assign de_pc     = de_valid ? q_pc[rd_ptr] : '0;
  assign de_pc_inc = de_pc + XLEN'(4);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= RESET_VEC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates visibility of every entry.
  always_ff @(posedge CLK) begin
    if (!RST && !redirect && push) begin
      q_pc[wr_ptr] <= inflight_pc;
      q_ir[wr_ptr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
`default_nettype none
// Directed testbench for otter_fetch_queue with a one-cycle synchronous imem model.
module tb_otter_fetch_queue;

  localparam int          XLEN   = 32;
  localparam int          QDEPTH = 4;
  localparam logic [31:0] RVEC   = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        de_valid;
  logic        de_ready = 1'b0;
  logic [31:0] de_ir;
  logic [31:0] de_pc;
  logic [31:0] de_pc_inc;
  logic [2:0]  count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  otter_fetch_queue #(.XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_VEC(RVEC)) dut (
    .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_rden(imem_rden),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .de_valid(de_valid), .de_ready(de_ready), .de_ir(de_ir), .de_pc(de_pc),
    .de_pc_inc(de_pc_inc), .count(count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  always @(posedge CLK) if (imem_rden) imem_rdata <= mem_word(imem_addr);

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset_startup();
    RST = 1'b1; de_ready = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (imem_rden !== 1'b0) begin errors++; $display("FAIL rst_rden got %0b want 0", imem_rden); end
    checks++; if (imem_addr !== RVEC) begin errors++; $display("FAIL rst_addr got %h want %h", imem_addr, RVEC); end
    checks++; if (de_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rst_empty valid %0b count %0d want 0 0", de_valid, count); end
    checks++; if (de_ir !== NOP || de_pc !== 32'h0) begin errors++; $display("FAIL rst_head ir %h pc %h want %h 0", de_ir, de_pc, NOP); end
    RST = 1'b0;
    #1;
    checks++; if (imem_rden !== 1'b1 || imem_addr !== RVEC) begin errors++; $display("FAIL start_c0 rden %0b addr %h want 1 %h", imem_rden, imem_addr, RVEC); end
    tick();
    checks++; if (de_valid !== 1'b0 || imem_addr !== 32'h104) begin errors++; $display("FAIL start_c1 valid %0b addr %h want 0 104", de_valid, imem_addr); end
    tick();
    exp_pc = RVEC;
    for (int k = 0; k < 8; k++) begin
      checks++; if (de_valid !== 1'b1 || de_pc !== exp_pc) begin errors++; $display("FAIL start_stream k%0d valid %0b pc %h want 1 %h", k, de_valid, de_pc, exp_pc); end
      checks++; if (de_ir !== mem_word(exp_pc) || count !== 3'd1) begin errors++; $display("FAIL start_ir k%0d ir %h count %0d want %h 1", k, de_ir, count, mem_word(exp_pc)); end
      exp_pc = exp_pc + 32'd4;
      tick();
    end
  endtask

  task automatic test_back_pressure();
    de_ready = 1'b0;
    repeat (10) tick();
    #1;
    checks++; if (count !== 3'd4 || imem_rden !== 1'b0) begin errors++; $display("FAIL bp_full count %0d rden %0b want 4 0", count, imem_rden); end
    checks++; if (de_pc !== exp_pc) begin errors++; $display("FAIL bp_head pc %h want %h", de_pc, exp_pc); end
    de_ready = 1'b1;
    #1;
    checks++; if (imem_rden !== 1'b1) begin errors++; $display("FAIL bp_credit rden %0b want 1", imem_rden); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (de_valid !== 1'b1 || de_pc !== exp_pc || de_ir !== mem_word(exp_pc)) begin errors++; $display("FAIL bp_stream k%0d valid %0b pc %h ir %h want 1 %h", k, de_valid, de_pc, de_ir, exp_pc); end
      exp_pc = exp_pc + 32'd4;
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL bp_after count %0d want 3", count); end
  endtask

  task automatic test_redirect_full();
    de_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd3 || imem_rden !== 1'b0) begin errors++; $display("FAIL rf_nocredit count %0d rden %0b want 3 0", count, imem_rden); end
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0; de_ready = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || de_valid !== 1'b0) begin errors++; $display("FAIL rf_flush count %0d valid %0b want 0 0", count, de_valid); end
    checks++; if (imem_addr !== 32'h200 || imem_rden !== 1'b1) begin errors++; $display("FAIL rf_addr addr %h rden %0b want 200 1", imem_addr, imem_rden); end
    tick();
    checks++; if (de_valid !== 1'b0 || de_ir !== NOP) begin errors++; $display("FAIL rf_t2 valid %0b ir %h want 0 %h", de_valid, de_ir, NOP); end
    tick();
    exp_pc = 32'h200;
    for (int k = 0; k < 5; k++) begin
      checks++; if (de_valid !== 1'b1 || de_pc !== exp_pc || de_ir !== mem_word(exp_pc)) begin errors++; $display("FAIL rf_stream k%0d valid %0b pc %h ir %h want 1 %h", k, de_valid, de_pc, de_ir, exp_pc); end
      exp_pc = exp_pc + 32'd4;
      tick();
    end
  endtask

  task automatic test_redirect_pop_push();
    #1;
    checks++; if (de_valid !== 1'b1 || imem_rden !== 1'b1) begin errors++; $display("FAIL rpp_pre valid %0b rden %0b want 1 1", de_valid, imem_rden); end
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || de_valid !== 1'b0) begin errors++; $display("FAIL rpp_flush count %0d valid %0b want 0 0", count, de_valid); end
    tick();
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL rpp_t2 valid %0b want 0", de_valid); end
    tick();
    exp_pc = 32'h300;
    for (int k = 0; k < 5; k++) begin
      checks++; if (de_valid !== 1'b1 || de_pc !== exp_pc || de_ir !== mem_word(exp_pc)) begin errors++; $display("FAIL rpp_stream k%0d valid %0b pc %h ir %h want 1 %h", k, de_valid, de_pc, de_ir, exp_pc); end
      exp_pc = exp_pc + 32'd4;
      tick();
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (de_valid !== 1'b1 || de_pc !== 32'hFFFF_FFFC || de_ir !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_first valid %0b pc %h ir %h want 1 fffffffc", de_valid, de_pc, de_ir); end
    checks++; if (de_pc_inc !== 32'h0) begin errors++; $display("FAIL wrap_inc got %h want 0", de_pc_inc); end
    tick();
    checks++; if (de_pc !== 32'h0 || de_pc_inc !== 32'h4 || de_ir !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_second pc %h inc %h ir %h want 0 4", de_pc, de_pc_inc, de_ir); end
    tick();
    checks++; if (de_pc !== 32'h4) begin errors++; $display("FAIL wrap_third pc %h want 4", de_pc); end
    tick();
  endtask

  task automatic test_reset_mid();
    de_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (count !== 3'd3 || imem_rden !== 1'b0) begin errors++; $display("FAIL rm_pre count %0d rden %0b want 3 0", count, imem_rden); end
    RST = 1'b1;
    #1;
    checks++; if (imem_rden !== 1'b0) begin errors++; $display("FAIL rm_rst_rden got %0b want 0", imem_rden); end
    tick();
    RST = 1'b0;
    #1;
    checks++; if (de_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rm_empty valid %0b count %0d want 0 0", de_valid, count); end
    checks++; if (imem_addr !== RVEC || imem_rden !== 1'b1) begin errors++; $display("FAIL rm_c0 addr %h rden %0b want %h 1", imem_addr, imem_rden, RVEC); end
    de_ready = 1'b1;
    tick();
    checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL rm_c1 valid %0b want 0", de_valid); end
    tick();
    exp_pc = RVEC;
    for (int k = 0; k < 4; k++) begin
      checks++; if (de_valid !== 1'b1 || de_pc !== exp_pc || de_ir !== mem_word(exp_pc)) begin errors++; $display("FAIL rm_stream k%0d valid %0b pc %h ir %h want 1 %h", k, de_valid, de_pc, de_ir, exp_pc); end
      exp_pc = exp_pc + 32'd4;
      tick();
    end
  endtask

  initial begin
    test_reset_startup();
    test_back_pressure();
    test_redirect_full();
    test_redirect_pop_push();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
